// File: rtl/wb_master.sv
// Single-outstanding Wishbone B4 pipelined master.
// Client request/response in; one bus cycle per request with timeout.
module wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_sel_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic busy;
  logic accept;
  logic ack_ok;
  logic tmo;

  assign busy   = (state_q == S_REQ) || (state_q == S_WAIT);
  assign accept = (state_q == S_IDLE) && req_i;
  // Ack only counts once the strobe has been taken by the slave.
  assign ack_ok = wb_ack_i &&
                  (((state_q == S_REQ) && !wb_stall_i) ||
                   (state_q == S_WAIT));
  assign tmo    = busy && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    we_d     = we_q;
    sel_d    = sel_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (accept) begin
      state_d = S_REQ;
      cnt_d   = '0;
      adr_d   = req_addr_i;
      dat_d   = req_wdata_i;
      we_d    = req_we_i;
      sel_d   = req_sel_i;
    end else if (ack_ok) begin
      // Ack beats a coincident timeout.
      state_d  = S_IDLE;
      rvalid_d = 1'b1;
      rdata_d  = we_q ? '0 : wb_dat_i;
      err_d    = 1'b0;
    end else if (tmo) begin
      state_d  = S_IDLE;
      rvalid_d = 1'b1;
      rdata_d  = '0;
      err_d    = 1'b1;
    end else if (busy) begin
      cnt_d = cnt_q + 16'd1;
      if ((state_q == S_REQ) && !wb_stall_i) begin
        state_d = S_WAIT;
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign wb_cyc_o     = busy;
  assign wb_stb_o     = (state_q == S_REQ);
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_we_o      = we_q;
  assign wb_sel_o     = sel_q;
  assign resp_valid_o = rvalid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_wb_master.sv
// Directed bench for wb_master with an 8-cycle timeout.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_wb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sel;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic        wb_stb;
  logic        wb_ack;
  logic        wb_cyc;
  logic        wb_stall;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  wb_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_sel_i    (req_sel),
    .req_ready_o  (req_ready),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .wb_adr_o     (wb_adr),
    .wb_dat_o     (wb_dat_o),
    .wb_dat_i     (wb_dat_i),
    .wb_we_o      (wb_we),
    .wb_sel_o     (wb_sel),
    .wb_stb_o     (wb_stb),
    .wb_ack_i     (wb_ack),
    .wb_cyc_o     (wb_cyc),
    .wb_stall_i   (wb_stall)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (resp_valid) pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    req = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_sel = s;
    tick();
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; req_we = 1'b1;
    req_addr = 32'h55; req_wdata = 32'h66; req_sel = 4'hF;
    wb_dat_i = '0; wb_ack = 1'b0; wb_stall = 1'b0;
    tick(); tick();
    checks++;
    if ({wb_cyc, wb_stb, wb_we, resp_valid, resp_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 00000",
               {wb_cyc, wb_stb, wb_we, resp_valid, resp_err});
    end
    checks++;
    if ({wb_adr, wb_dat_o, wb_sel, resp_rdata} !== 100'h0) begin
      errors++;
      $display("FAIL reset_data adr=%h dat=%h sel=%h rdata=%h want 0",
               wb_adr, wb_dat_o, wb_sel, resp_rdata);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", req_ready);
    end
    req = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    issue(1'b0, 32'h8, 32'h0, 4'hF);
    checks++;
    if ({wb_cyc, wb_stb, req_ready, wb_we} !== 4'b1100 ||
        wb_adr !== 32'h8 || wb_sel !== 4'hF) begin
      errors++;
      $display("FAIL read_strobe cyc/stb/rdy/we=%b adr=%h sel=%h want 1100 8 f",
               {wb_cyc, wb_stb, req_ready, wb_we}, wb_adr, wb_sel);
    end
    wb_ack = 1'b1; wb_dat_i = 32'hDEADBEEF;
    tick();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    checks++;
    if ({resp_valid, resp_err, wb_cyc, wb_stb} !== 4'b1000 ||
        resp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_resp v/e/cyc/stb=%b rdata=%h want 1000 deadbeef",
               {resp_valid, resp_err, wb_cyc, wb_stb}, resp_rdata);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_hold v=%b rdata=%h want 0 deadbeef",
               resp_valid, resp_rdata);
    end
  endtask

  task automatic test_timeout();
    int n;
    wb_dat_i = 32'hCAFE0001;
    issue(1'b0, 32'h20, 32'h0, 4'h1);
    n = 0;
    while (wb_cyc && n < 20) begin
      n++;
      tick();
    end
    wb_dat_i = 32'h0;
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL timeout_len cyc cycles=%0d want 8", n);
    end
    checks++;
    if ({resp_valid, resp_err} !== 2'b11 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL timeout_resp v/e=%b rdata=%h want 11 0",
               {resp_valid, resp_err}, resp_rdata);
    end
    tick();
  endtask

  task automatic test_write_stall();
    int stb_n;
    int bad;
    issue(1'b1, 32'hC, 32'h41, 4'h3);
    wb_stall = 1'b1;
    stb_n = 0; bad = 0;
    for (int i = 0; i < 3; i++) begin
      wb_ack = (i == 0);
      if (wb_stb) stb_n++;
      if (wb_dat_o !== 32'h41 || wb_adr !== 32'hC) bad++;
      tick();
    end
    wb_ack = 1'b0; wb_stall = 1'b0;
    if (wb_stb) stb_n++;
    tick();
    checks++;
    if (stb_n !== 4 || wb_stb !== 1'b0 || wb_cyc !== 1'b1) begin
      errors++;
      $display("FAIL wr_stb stb cycles=%0d stb=%b cyc=%b want 4 0 1",
               stb_n, wb_stb, wb_cyc);
    end
    if (wb_dat_o !== 32'h41 || wb_we !== 1'b1) bad++;
    tick();
    checks++;
    if (wb_cyc !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_wait cyc=%b v=%b want 1 0", wb_cyc, resp_valid);
    end
    wb_ack = 1'b1; wb_dat_i = 32'h99;
    tick();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    checks++;
    if ({resp_valid, resp_err, wb_cyc} !== 3'b100 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL wr_resp v/e/cyc=%b rdata=%h want 100 0",
               {resp_valid, resp_err, wb_cyc}, resp_rdata);
    end
    checks++;
    if (bad !== 0 || wb_dat_o !== 32'h41 || wb_adr !== 32'hC ||
        wb_sel !== 4'h3) begin
      errors++;
      $display("FAIL wr_stable bad=%0d dat=%h adr=%h sel=%h want 0 41 c 3",
               bad, wb_dat_o, wb_adr, wb_sel);
    end
    tick();
  endtask

  task automatic test_collision();
    issue(1'b0, 32'h30, 32'h0, 4'hF);
    repeat (7) tick();
    checks++;
    if (wb_cyc !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL coll_pre cyc=%b v=%b want 1 0", wb_cyc, resp_valid);
    end
    wb_ack = 1'b1; wb_dat_i = 32'h12345678;
    tick();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    checks++;
    if ({resp_valid, resp_err, wb_cyc} !== 3'b100 ||
        resp_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL coll_resp v/e/cyc=%b rdata=%h want 100 12345678",
               {resp_valid, resp_err, wb_cyc}, resp_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulses;
    issue(1'b0, 32'h10, 32'h0, 4'hF);
    wb_ack = 1'b1; wb_dat_i = 32'hAAAA5555;
    tick();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    checks++;
    if ({resp_valid, req_ready, wb_cyc} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_gap v/rdy/cyc=%b want 110",
               {resp_valid, req_ready, wb_cyc});
    end
    issue(1'b1, 32'h14, 32'h5, 4'hF);
    checks++;
    if ({wb_cyc, wb_stb, resp_valid} !== 3'b110 || wb_adr !== 32'h14) begin
      errors++;
      $display("FAIL b2b_second cyc/stb/v=%b adr=%h want 110 14",
               {wb_cyc, wb_stb, resp_valid}, wb_adr);
    end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    tick();
    checks++;
    if (pulses - p0 !== 2 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL b2b_pulses got %0d rdata=%h want 2 0",
               pulses - p0, resp_rdata);
    end
  endtask

  task automatic test_reset_wait();
    int p0;
    issue(1'b0, 32'h40, 32'h7, 4'h2);
    tick();
    checks++;
    if ({wb_cyc, wb_stb} !== 2'b10) begin
      errors++;
      $display("FAIL rw_state cyc/stb=%b want 10", {wb_cyc, wb_stb});
    end
    p0 = pulses;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wb_ack = 1'b1; wb_dat_i = 32'h77;
    tick();
    wb_ack = 1'b0; wb_dat_i = 32'h0;
    tick();
    checks++;
    if (pulses !== p0 || {wb_cyc, wb_stb, resp_valid, resp_err} !== 4'b0) begin
      errors++;
      $display("FAIL rw_nopulse pulses=%0d ctl=%b want %0d 0000",
               pulses - p0, {wb_cyc, wb_stb, resp_valid, resp_err}, 0);
    end
    checks++;
    if ({wb_adr, wb_dat_o, resp_rdata} !== 96'h0 || wb_sel !== 4'h0 ||
        wb_we !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rw_outs adr=%h dat=%h rd=%h sel=%h we=%b rdy=%b",
               wb_adr, wb_dat_o, resp_rdata, wb_sel, wb_we, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_timeout();
    test_write_stall();
    test_collision();
    test_back_to_back();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
